// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: write-back request, commit and status bus; read-bypass signals exist only with REGFILE_WB_BYPASS_EN
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_ready;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_data_in;
    logic              flush;
    logic              busy;
    logic [15:0]       wb_count;
`ifdef REGFILE_WB_BYPASS_EN
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rf_data_out1;
    logic [DATA_W-1:0] rf_data_out2;
    logic [DATA_W-1:0] byp_data1;
    logic [DATA_W-1:0] byp_data2;

    modport slave (
        input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data, flush,
        input  rd_addr1, rd_addr2, rf_data_out1, rf_data_out2,
        output alu_ready, lsu_ready, rf_write_enable, rf_write_addr, rf_data_in, busy, wb_count,
        output byp_data1, byp_data2
    );
    modport master (
        output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data, flush,
        output rd_addr1, rd_addr2, rf_data_out1, rf_data_out2,
        input  alu_ready, lsu_ready, rf_write_enable, rf_write_addr, rf_data_in, busy, wb_count,
        input  byp_data1, byp_data2
    );
`else
    modport slave (
        input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data, flush,
        output alu_ready, lsu_ready, rf_write_enable, rf_write_addr, rf_data_in, busy, wb_count
    );
    modport master (
        output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data, flush,
        input  alu_ready, lsu_ready, rf_write_enable, rf_write_addr, rf_data_in, busy, wb_count
    );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin ALU/LSU write-back arbiter feeding the regfile write port; REGFILE_WB_BYPASS_EN adds read forwarding
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              gnt_alu, gnt_lsu;

    // a lone requester wins; a tie goes to whoever did not win last; x0 writes are accepted but never enabled
    always_comb begin
        gnt_alu = !bus.flush && bus.alu_valid && (!bus.lsu_valid || last_q);
        gnt_lsu = !bus.flush && bus.lsu_valid && (!bus.alu_valid || !last_q);
        last_d  = gnt_alu ? 1'b0 : gnt_lsu ? 1'b1 : last_q;
        addr_d  = gnt_alu ? bus.alu_addr : gnt_lsu ? bus.lsu_addr : addr_q;
        data_d  = gnt_alu ? bus.alu_data : gnt_lsu ? bus.lsu_data : data_q;
        we_d    = (gnt_alu || gnt_lsu) && addr_d != '0;
        cnt_d   = cnt_q + {15'd0, we_q};
    end

    // output stage and commit counter; reset leaves last = LSU so the ALU wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.alu_ready       = gnt_alu;
    assign bus.lsu_ready       = gnt_lsu;
    assign bus.rf_write_enable = we_q;
    assign bus.rf_write_addr   = addr_q;
    assign bus.rf_data_in      = data_q;
    assign bus.busy            = we_q;
    assign bus.wb_count        = cnt_q;

`ifdef REGFILE_WB_BYPASS_EN
    // forward the write in flight so reads never see the pre-write regfile value
    always_comb begin
        bus.byp_data1 = (we_q && bus.rd_addr1 == addr_q) ? data_q : bus.rf_data_out1;
        bus.byp_data2 = (we_q && bus.rd_addr2 == addr_q) ? data_q : bus.rf_data_out2;
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    typedef struct {
        int unsigned cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();
    regfile_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    wr_t         q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 0;
    bit          m_last = 1;
    logic [15:0] m_cnt = 0;
    bit          a_new = 1;
    bit          l_new = 1;
    int          a_seq = 1;
    int          l_seq = 10;
    logic        due;
    logic [31:0] exp_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // mode: 0 random, 1 both valid with sequential addresses, 2 ALU only to fix, 3 LSU writes x0, other idle
    task automatic gen(input int mode, input logic [4:0] fix);
        if (a_new) begin
            a_new = 0;
            bus.alu_valid = 1'b0;
            bus.alu_data  = $urandom;
            if (mode == 0) begin
                bus.alu_valid = $urandom_range(0, 3) != 0;
                bus.alu_addr  = $urandom_range(0, 4) == 0 ? 5'd0 : 5'($urandom);
            end else if (mode == 1) begin
                bus.alu_valid = 1'b1;
                bus.alu_addr  = 5'(a_seq);
                a_seq++;
            end else if (mode == 2) begin
                bus.alu_valid = 1'b1;
                bus.alu_addr  = fix;
            end
        end
        if (l_new) begin
            l_new = 0;
            bus.lsu_valid = 1'b0;
            bus.lsu_data  = $urandom;
            if (mode == 0) begin
                bus.lsu_valid = $urandom_range(0, 3) != 0;
                bus.lsu_addr  = $urandom_range(0, 4) == 0 ? 5'd0 : 5'($urandom);
            end else if (mode == 1) begin
                bus.lsu_valid = 1'b1;
                bus.lsu_addr  = 5'(l_seq);
                l_seq++;
            end else if (mode == 3) begin
                bus.lsu_valid = 1'b1;
                bus.lsu_addr  = 5'd0;
                bus.lsu_data  = 32'hDEADBEEF;
            end
        end
    endtask

    // drive one request set per cycle and score the grant against the round-robin rules
    task automatic run(input int n, input int mode, input logic [4:0] fix, input int fl_pct);
        logic ga, gl;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            gen(mode, fix);
            bus.flush = $urandom_range(0, 99) < fl_pct;
`ifdef REGFILE_WB_BYPASS_EN
            bus.rd_addr1     = (q.size() != 0 && $urandom_range(0, 1) == 1) ? q[$].addr : 5'($urandom);
            bus.rd_addr2     = 5'($urandom);
            bus.rf_data_out1 = $urandom;
            bus.rf_data_out2 = $urandom;
`endif
            @(negedge clk);
            ga = !bus.flush && bus.alu_valid && (!bus.lsu_valid || m_last);
            gl = !bus.flush && bus.lsu_valid && (!bus.alu_valid || !m_last);
            chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, ga});
            chk("lsu_ready", {31'd0, bus.lsu_ready}, {31'd0, gl});
            if (ga && bus.alu_addr != 0) q.push_back('{cyc + 1, bus.alu_addr, bus.alu_data});
            if (gl && bus.lsu_addr != 0) q.push_back('{cyc + 1, bus.lsu_addr, bus.lsu_data});
            if (ga) m_last = 0;
            if (gl) m_last = 1;
            a_new = ga || !bus.alu_valid;
            l_new = gl || !bus.lsu_valid;
        end
    endtask

    // monitor: every cycle the write port must show exactly the write the scoreboard says is due
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() != 0 && q[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale_entry: write for cycle %0d never retired", q[0].cyc);
                void'(q.pop_front());
            end
            due = q.size() != 0 && q[0].cyc == cyc;
            chk("wb_count", {16'd0, bus.wb_count}, {16'd0, m_cnt});
            chk("rf_write_enable", {31'd0, bus.rf_write_enable}, {31'd0, due});
            chk("busy", {31'd0, bus.busy}, {31'd0, due});
            if (due) begin
                chk("rf_write_addr", {27'd0, bus.rf_write_addr}, {27'd0, q[0].addr});
                chk("rf_data_in", bus.rf_data_in, q[0].data);
            end
`ifdef REGFILE_WB_BYPASS_EN
            exp_b = (due && bus.rd_addr1 == q[0].addr) ? q[0].data : bus.rf_data_out1;
            chk("byp_data1", bus.byp_data1, exp_b);
            exp_b = (due && bus.rd_addr2 == q[0].addr) ? q[0].data : bus.rf_data_out2;
            chk("byp_data2", bus.byp_data2, exp_b);
`endif
            if (due) begin
                void'(q.pop_front());
                m_cnt++;
            end
        end
    end

    initial begin
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_addr = 0; bus.lsu_data = 0;
        bus.flush = 0;
`ifdef REGFILE_WB_BYPASS_EN
        bus.rd_addr1 = 0; bus.rd_addr2 = 0; bus.rf_data_out1 = 0; bus.rf_data_out2 = 0;
`endif
        #12;
        chk("reset_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("reset_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
        chk("reset_we", {31'd0, bus.rf_write_enable}, 32'd0);
        chk("reset_addr", {27'd0, bus.rf_write_addr}, 32'd0);
        chk("reset_data", bus.rf_data_in, 32'd0);
        chk("reset_wb_count", {16'd0, bus.wb_count}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        mon_en = 1;
        run(3000, 0, 5'd0, 12);
        run(4, 5, 5'd0, 0);
        run(4, 1, 5'd0, 0);
        run(4, 5, 5'd0, 0);
        run(3, 3, 5'd0, 0);
        run(4, 5, 5'd0, 0);
        run(1, 1, 5'd0, 0);
        run(1, 1, 5'd0, 100);
        run(3, 1, 5'd0, 0);
        run(4, 5, 5'd0, 0);
        run(3, 1, 5'd0, 0);
        @(posedge clk);
        #2;
        mon_en = 0;
        rst_n = 0;
        #1;
        chk("async_reset_we", {31'd0, bus.rf_write_enable}, 32'd0);
        chk("async_reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_reset_wb_count", {16'd0, bus.wb_count}, 32'd0);
        bus.alu_valid = 0;
        bus.lsu_valid = 0;
        bus.flush = 0;
        q.delete();
        m_last = 1;
        m_cnt = 0;
        a_new = 1;
        l_new = 1;
        @(negedge clk);
        rst_n = 1;
        mon_en = 1;
        run(1, 2, 5'd5, 0);
        run(3, 5, 5'd0, 0);
        run(65535, 2, 5'd3, 0);
        run(3, 5, 5'd0, 0);
        chk("wb_count_wrap", {16'd0, bus.wb_count}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
